instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the opcode-to-control decoder: turns a symbolic instruction request (mnemonic select plus register/immediate fields) into a 32-bit MIPS instruction word.
- Used by the boot/test loader to fill instruction memory.
- Input side and output side are each a valid/ready stream.
- A registered encode stage feeds an output FIFO.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, at least 2).
- CW, 3, width of out_count; must equal clog2(DEPTH+1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of the FIFO; reset takes precedence.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when high together with in_valid.
- in_op  input  5  mnemonic select, see Behaviour.
- in_rs  input  5  rs field.
- in_rt  input  5  rt field.
- in_rd  input  5  rd field.
- in_imm  input  16  immediate or branch offset.
- in_target  input  26  jump target.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer ready.
- out_instr  output  32  encoded word at FIFO head.
- out_count  output  CW  FIFO occupancy.
- err_illegal  output  1  one-cycle pulse for a rejected in_op.

Behaviour:
- Mnemonic map for in_op:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT.
  - 6 ADDI, 7 SLTI, 8 ANDI, 9 ORI, 10 XORI, 11 LUI.
  - 12 LW, 13 SW, 14 BEQ, 15 J.
  - 16..31 are illegal.
- R-type (ops 0-5): {6'h00, rs, rt, rd, 5'b0, funct}. funct is ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, SLT 0x2A.
- I-type: {opcode, rs, rt, imm}. Opcodes: ADDI 0x08, SLTI 0x0A, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F, LW 0x23, SW 0x2B, BEQ 0x04.
- LUI forces the rs field to 0.
- J: {6'h02, target}.
- Fields not used by a format are ignored.
- in_ready = (out_count < DEPTH) and not reset. It is registered-state only, with no combinational path from out_ready.
- Accept on rising edge where in_valid && in_ready:
  - Legal op: the word is written at the FIFO tail at that edge.
  - Next cycle: out_valid=1 if the FIFO was empty, i.e. latency is 1 cycle.
- Illegal op: the handshake completes, nothing is written, and err_illegal=1 for exactly the following cycle.
- Pop on edge where out_valid && out_ready. out_instr always shows the head. out_instr is 0 when the FIFO is empty.
- Simultaneous push and pop when not full and not empty: out_count is unchanged and order is preserved.
- Push and pop when empty: the push is not bypassed; the word appears next cycle.
- Full: in_ready=0 even if out_ready=1 in the same cycle.
- Read and write pointers wrap modulo DEPTH.
- reset or flush:
  - out_count=0, out_valid=0, out_instr=0, err_illegal=0, pointers=0.
  - The in-flight accept in that cycle is discarded.
- Reset mid-stream loses all queued words.

Optional Feature:
- INSTR_ENC_PARITY_EN defined:
  - Adds output out_parity (1 bit) = even parity (XOR reduction) of out_instr, stored per entry.
  - 0 when the FIFO is empty.
- Undefined: the port and storage are absent; all other behaviour is identical.

Test Plan:
- ADD rs=1 rt=2 rd=3 into empty FIFO -> next cycle out_valid=1, out_instr=0x00221820, out_count=1.
- ADDI rs=0 rt=8 imm=5; then LW rs=29 rt=9 imm=4, with out_ready=1 -> 0x20080005 then 0x8FA90004 in order, each popped one cycle after its push.
- J target=0x0100000 -> 0x08100000. LUI rs=5 rt=1 imm=0x1234 -> 0x3C011234 (rs forced to 0).
- in_op=20 -> no write, out_count unchanged, err_illegal high exactly one cycle.
- Push DEPTH words with out_ready=0:
  - in_ready falls after the 4th push.
  - Asserting out_ready=1 gives in_ready=1 one cycle later.
  - Words drain in FIFO order across pointer wrap.
- Fill with 3 words, assert reset (or flush) for 1 cycle alongside in_valid -> out_count=0, out_valid=0, out_instr=0; the next push appears alone.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests into 32-bit MIPS words and queues them in an output FIFO.
// Define INSTR_ENC_PARITY_EN to add the per-entry out_parity output.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [CW-1:0] out_count,
`ifdef INSTR_ENC_PARITY_EN
  output logic          out_parity,
`endif
  output logic          err_illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Returns {legal, word}; ops 16..31 come back with legal cleared.
  function automatic logic [32:0] encode(input logic [4:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm, input logic [25:0] tgt);
    logic [32:0] res;
    res = 33'h0;
    case (op)
      5'd0:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h20};
      5'd1:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h22};
      5'd2:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h24};
      5'd3:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h25};
      5'd4:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h26};
      5'd5:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h2A};
      5'd6:  res = {1'b1, 6'h08, rs, rt, imm};
      5'd7:  res = {1'b1, 6'h0A, rs, rt, imm};
      5'd8:  res = {1'b1, 6'h0C, rs, rt, imm};
      5'd9:  res = {1'b1, 6'h0D, rs, rt, imm};
      5'd10: res = {1'b1, 6'h0E, rs, rt, imm};
      5'd11: res = {1'b1, 6'h0F, 5'd0, rt, imm};
      5'd12: res = {1'b1, 6'h23, rs, rt, imm};
      5'd13: res = {1'b1, 6'h2B, rs, rt, imm};
      5'd14: res = {1'b1, 6'h04, rs, rt, imm};
      5'd15: res = {1'b1, 6'h02, tgt};
      default: res = 33'h0;
    endcase
    return res;
  endfunction

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q;
  logic [32:0]   enc_s;
  logic          accept_s, push_s, pop_s;

  assign enc_s     = encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
  assign in_ready  = (count_q < CW'(DEPTH)) && !reset;
  assign accept_s  = in_valid && in_ready;
  assign push_s    = accept_s && enc_s[32];
  assign out_valid = (count_q != '0);
  assign pop_s     = out_valid && out_ready;
  assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign out_count = count_q;
  assign err_illegal = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_s)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Reset dominates flush; both discard the accept presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= accept_s && !enc_s[32];
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= enc_s[31:0];
  end

`ifdef INSTR_ENC_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push_s) par_q[wr_ptr_q] <= ^enc_s[31:0];
  end

  assign out_parity = out_valid ? par_q[rd_ptr_q] : 1'b0;
`endif

endmodule
